// File: rtl/mips_core_pkg.sv
// Shared store-buffer types: FSM state and entry record. Default address/data
// widths are 32 bits unless ADDR_WIDTH / DATA_WIDTH are already defined.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package mips_core_pkg;
    localparam int ADDR_W  = `ADDR_WIDTH;
    localparam int DATA_W  = `DATA_WIDTH;
    localparam int WADDR_W = ADDR_W - 2;

    typedef enum logic [1:0] {
        SB_IDLE,
        SB_DRAIN,
        SB_FENCE
    } SbState;

    typedef struct packed {
        logic               valid;
        logic [WADDR_W-1:0] addr;
        logic [DATA_W-1:0]  data;
    } SbEntry;

    function automatic logic [WADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1:2];
    endfunction
endpackage

// File: rtl/sb_forward_match.sv
// Store-to-load forwarding lookup: scans entries from youngest (just behind
// wr_ptr) to oldest and returns the first valid word-address match.
module sb_forward_match
    import mips_core_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  SbEntry             entries [DEPTH],
    input  logic [PTR_W-1:0]   wr_ptr,
    input  logic [WADDR_W-1:0] ld_waddr,
    output logic               hit,
    output logic [DATA_W-1:0]  data
);
    SbEntry cand;

    always_comb begin
        hit  = 1'b0;
        data = '0;
        cand = '0;
        for (int k = 1; k <= DEPTH; k++) begin
            cand = entries[wr_ptr - PTR_W'(k)];
            if (!hit && cand.valid && (cand.addr == ld_waddr)) begin
                hit  = 1'b1;
                data = cand.data;
            end
        end
    end
endmodule

// File: rtl/store_buffer_ctrl.sv
// Word-granular store buffer between MEM and the D-cache: in-order drain,
// load forwarding, fence drain. Optional STORE_BUFFER_COALESCE_EN merges stores.
module store_buffer_ctrl
    import mips_core_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   st_valid,
    input  logic [`ADDR_WIDTH-1:0] st_addr,
    input  logic [`DATA_WIDTH-1:0] st_data,
    output logic                   st_ready,
    input  logic                   ld_valid,
    input  logic [`ADDR_WIDTH-1:0] ld_addr,
    output logic                   sb_hit,
    output logic                   sb_valid,
    output logic [`DATA_WIDTH-1:0] sb_data,
    input  logic                   cache_busy,
    output logic                   drain_valid,
    output logic [`ADDR_WIDTH-1:0] drain_addr,
    output logic [`DATA_WIDTH-1:0] drain_data,
    input  logic                   drain_ready,
    input  logic                   fence,
    output logic                   empty,
    output logic                   sb_stall
);
    SbState             state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]     count_q, count_d;
    logic [DEPTH-1:0]   valid_q, valid_d;
    logic               fence_seen_q, fence_seen_d;
    logic [WADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0]  data_q [DEPTH];
    SbEntry             entries [DEPTH];
    logic               base_ready, coal_ok, alloc, deq;
    logic [3:0]         unused_addr_bits;

    assign unused_addr_bits = {st_addr[1:0], ld_addr[1:0]};

    assign base_ready = (count_q != (PTR_W+1)'(DEPTH)) && (state_q != SB_FENCE);

`ifdef STORE_BUFFER_COALESCE_EN
    logic [PTR_W-1:0] young_ptr;
    logic             coal_wr;
    assign young_ptr = wr_ptr_q - PTR_W'(1);
    // The head entry under an active drain offer must stay stable, so never merge into it.
    assign coal_ok = (count_q != '0) && valid_q[young_ptr] &&
                     (addr_q[young_ptr] == word_addr(st_addr)) && (state_q != SB_FENCE) &&
                     !((state_q == SB_DRAIN) && (young_ptr == rd_ptr_q));
    assign coal_wr = st_valid && coal_ok;
`else
    assign coal_ok = 1'b0;
`endif

    assign st_ready = base_ready || coal_ok;
    assign alloc    = st_valid && base_ready && !coal_ok;
    assign deq      = drain_valid && drain_ready;
    assign empty    = (count_q == '0);
    assign sb_stall = (st_valid && !st_ready) || (state_q == SB_FENCE);
    assign sb_valid = ld_valid && sb_hit;

    assign drain_addr = {addr_q[rd_ptr_q], 2'b00};
    assign drain_data = data_q[rd_ptr_q];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entries[i] = {valid_q[i], addr_q[i], data_q[i]};
        end
    end

    sb_forward_match #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_match (
        .entries  (entries),
        .wr_ptr   (wr_ptr_q),
        .ld_waddr (word_addr(ld_addr)),
        .hit      (sb_hit),
        .data     (sb_data)
    );

    always_comb begin
        state_d      = state_q;
        fence_seen_d = 1'b0;
        drain_valid  = 1'b0;
        case (state_q)
            SB_IDLE: begin
                if (fence) begin
                    state_d = SB_FENCE;
                end else if ((count_q != '0) && !cache_busy) begin
                    state_d = SB_DRAIN;
                end
            end
            SB_DRAIN: begin
                drain_valid  = 1'b1;
                fence_seen_d = fence_seen_q || fence;
                if (drain_ready) begin
                    fence_seen_d = 1'b0;
                    if (fence_seen_q || fence) begin
                        state_d = SB_FENCE;
                    end else if (((count_q == (PTR_W+1)'(1)) && !alloc) || cache_busy) begin
                        state_d = SB_IDLE;
                    end
                end
            end
            SB_FENCE: begin
                drain_valid = (count_q != '0);
                if ((count_q == '0) && !fence) begin
                    state_d = SB_IDLE;
                end
            end
            default: state_d = SB_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = alloc ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = deq ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        if (alloc && !deq) begin
            count_d = count_q + (PTR_W+1)'(1);
        end else if (!alloc && deq) begin
            count_d = count_q - (PTR_W+1)'(1);
        end
        valid_d = valid_q;
        if (deq) begin
            valid_d[rd_ptr_q] = 1'b0;
        end
        if (alloc) begin
            valid_d[wr_ptr_q] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= SB_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            valid_q      <= '0;
            fence_seen_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            valid_q      <= valid_d;
            fence_seen_q <= fence_seen_d;
        end
    end

    // Payload storage carries no reset; the valid bits alone qualify it.
    always_ff @(posedge clk) begin
        if (alloc) begin
            addr_q[wr_ptr_q] <= word_addr(st_addr);
            data_q[wr_ptr_q] <= st_data;
        end
`ifdef STORE_BUFFER_COALESCE_EN
        else if (coal_wr) begin
            data_q[young_ptr] <= st_data;
        end
`endif
    end
endmodule

// File: tb/tb_store_buffer_ctrl.sv
// Self-checking bench for store_buffer_ctrl: lookup vector table, drain-order
// scoreboard, and sequences for full, wrap, fence and reset-mid-drain.
module tb_store_buffer_ctrl;
    import mips_core_pkg::*;

    localparam int DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              st_valid = 1'b0;
    logic [ADDR_W-1:0] st_addr = '0;
    logic [DATA_W-1:0] st_data = '0;
    logic              st_ready;
    logic              ld_valid = 1'b0;
    logic [ADDR_W-1:0] ld_addr = '0;
    logic              sb_hit, sb_valid;
    logic [DATA_W-1:0] sb_data;
    logic              cache_busy = 1'b0;
    logic              drain_valid;
    logic [ADDR_W-1:0] drain_addr;
    logic [DATA_W-1:0] drain_data;
    logic              drain_ready = 1'b0;
    logic              fence = 1'b0;
    logic              empty, sb_stall;

    store_buffer_ctrl #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready),
        .ld_valid(ld_valid), .ld_addr(ld_addr),
        .sb_hit(sb_hit), .sb_valid(sb_valid), .sb_data(sb_data),
        .cache_busy(cache_busy),
        .drain_valid(drain_valid), .drain_addr(drain_addr), .drain_data(drain_data),
        .drain_ready(drain_ready), .fence(fence),
        .empty(empty), .sb_stall(sb_stall)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_drained = 0;
    bit toggle_en = 1'b0;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        logic              ld_v;
        logic [ADDR_W-1:0] ld_a;
        logic              st_v;
        logic [ADDR_W-1:0] st_a;
        logic              hit;
        logic              sbv;
        logic [DATA_W-1:0] data;
        logic              rdy;
        logic              stall;
    } vec_t;
    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: accepted stores queued in order, popped on every drain handshake.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n) begin
            if (st_valid && st_ready) begin
                e.addr = {st_addr[ADDR_W-1:2], 2'b00};
                e.data = st_data;
`ifdef STORE_BUFFER_COALESCE_EN
                if (sbq.size() > 0 && sbq[sbq.size()-1].addr == e.addr &&
                    !(drain_valid && sbq.size() == 1))
                    sbq[sbq.size()-1] = e;
                else
                    sbq.push_back(e);
`else
                sbq.push_back(e);
`endif
            end
            if (drain_valid && drain_ready) begin
                if (sbq.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL drain_unexpected: got addr 0x%0h expected no drain", drain_addr);
                end else begin
                    e = sbq.pop_front();
                    chk("drain_addr", drain_addr, e.addr);
                    chk("drain_data", drain_data, e.data);
                    n_drained++;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (toggle_en) begin
            #1 drain_ready = ~drain_ready;
        end
    end

    task automatic do_store(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bit acc = 1'b0;
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        for (int i = 0; i < 40 && !acc; i++) begin
            @(negedge clk);
            if (st_ready) acc = 1'b1;
            cyc();
        end
        st_valid = 1'b0;
        chk("store_accept", acc, 1);
    endtask

    task automatic wait_dv(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            if (drain_valid) seen = 1'b1;
            else cyc();
        end
        chk(name, seen, 1);
    endtask

    task automatic wait_empty(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (empty) done = 1'b1;
            else cyc();
        end
        chk(name, done, 1);
        cyc();
    endtask

    initial begin
        #300000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int base;
        vecs[0] = '{1'b1, 32'h100, 1'b0, 32'h0,   1'b1, 1'b1, 32'hAAAA, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 32'h103, 1'b0, 32'h0,   1'b1, 1'b1, 32'hAAAA, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 32'h200, 1'b0, 32'h0,   1'b1, 1'b1, 32'h2,    1'b0, 1'b0};
        vecs[3] = '{1'b1, 32'h204, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,    1'b0, 1'b0};
        vecs[4] = '{1'b0, 32'h300, 1'b0, 32'h0,   1'b1, 1'b0, 32'h3,    1'b0, 1'b0};
        vecs[5] = '{1'b1, 32'h0,   1'b1, 32'h400, 1'b0, 1'b0, 32'h0,    1'b0, 1'b1};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_st_ready", st_ready, 1);
        chk("rst_empty", empty, 1);
        chk("rst_drain_valid", drain_valid, 0);
        chk("rst_sb_hit", sb_hit, 0);
        chk("rst_sb_data", sb_data, 0);
        chk("rst_sb_stall", sb_stall, 0);
        cyc();
        rst_n = 1'b1;
        cyc();

        // Fill with cache busy, then table-driven lookups
        cache_busy = 1'b1;
        do_store(32'h100, 32'hAAAA);
        do_store(32'h200, 32'h1);
        do_store(32'h200, 32'h2);
        do_store(32'h300, 32'h3);
`ifdef STORE_BUFFER_COALESCE_EN
        do_store(32'h500, 32'h5);
`endif
        for (int v = 0; v < 6; v++) begin
            ld_valid = vecs[v].ld_v;
            ld_addr  = vecs[v].ld_a;
            st_valid = vecs[v].st_v;
            st_addr  = vecs[v].st_a;
            st_data  = 32'h4444;
            @(negedge clk);
            chk($sformatf("vec%0d_sb_hit", v), sb_hit, vecs[v].hit);
            chk($sformatf("vec%0d_sb_valid", v), sb_valid, vecs[v].sbv);
            chk($sformatf("vec%0d_sb_data", v), sb_data, vecs[v].data);
            chk($sformatf("vec%0d_st_ready", v), st_ready, vecs[v].rdy);
            chk($sformatf("vec%0d_sb_stall", v), sb_stall, vecs[v].stall);
            chk($sformatf("vec%0d_drain_valid", v), drain_valid, 0);
            cyc();
        end
        st_valid = 1'b0;
        ld_valid = 1'b0;

        // Head held stable while drain_ready low, even when cache_busy rises mid-offer
        base = n_drained;
        cache_busy = 1'b0;
        wait_dv("head_offer");
        for (int k = 0; k < 3; k++) begin
            chk("hold_drain_valid", drain_valid, 1);
            chk("hold_drain_addr", drain_addr, 32'h100);
            chk("hold_drain_data", drain_data, 32'hAAAA);
            cyc();
            if (k == 0) cache_busy = 1'b1;
            @(negedge clk);
        end
        cyc();
        cache_busy  = 1'b0;
        drain_ready = 1'b1;
        wait_empty("full_drain_empty");
        chk("full_drain_count", n_drained - base, 4);

        // Wrap-around with drain_ready toggling
        base = n_drained;
        drain_ready = 1'b0;
        toggle_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            do_store(32'h10 + 32'(4 * i), 32'hD0 + 32'(i));
        end
        toggle_en = 1'b0;
        cyc();
        drain_ready = 1'b1;
        wait_empty("wrap_empty");
        chk("wrap_count", n_drained - base, 5);

        // Fence drains despite cache_busy and blocks stores
        base = n_drained;
        cache_busy = 1'b1;
        do_store(32'h40, 32'h4040);
        do_store(32'h44, 32'h4444);
        fence = 1'b1;
        cyc();
        st_valid = 1'b1;
        st_addr  = 32'h48;
        st_data  = 32'h4848;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("fence_st_ready", st_ready, 0);
            chk("fence_sb_stall", sb_stall, 1);
            cyc();
        end
        st_valid = 1'b0;
        @(negedge clk);
        chk("fence_empty", empty, 1);
        chk("fence_count", n_drained - base, 2);
        cyc();
        fence = 1'b0;
        cyc();
        @(negedge clk);
        chk("postfence_st_ready", st_ready, 1);
        chk("postfence_sb_stall", sb_stall, 0);
        chk("postfence_empty", empty, 1);
        chk("postfence_drain_valid", drain_valid, 0);
        cyc();

        // Reset in the middle of a drain offer
        cache_busy  = 1'b1;
        drain_ready = 1'b0;
        do_store(32'h60, 32'h6060);
        do_store(32'h64, 32'h6464);
        do_store(32'h68, 32'h6868);
        cache_busy = 1'b0;
        wait_dv("prereset_offer");
        cyc();
        rst_n = 1'b0;
        sbq.delete();
        cyc();
        rst_n = 1'b1;
        ld_valid = 1'b1;
        ld_addr  = 32'h64;
        @(negedge clk);
        chk("midrst_empty", empty, 1);
        chk("midrst_drain_valid", drain_valid, 0);
        chk("midrst_st_ready", st_ready, 1);
        chk("midrst_sb_hit", sb_hit, 0);
        cyc();
        ld_valid = 1'b0;

        chk("scoreboard_left", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
